// File: rtl/icache_refill_ctrl_pkg.sv
// icache_refill_ctrl_pkg: shared widths, polarity constants and FSM encoding for the fetch refill controller.
package icache_refill_ctrl_pkg;
    localparam int   ADDR_LEN     = 32;
    localparam int   INST_LEN     = 32;
    localparam logic RESET_ENABLE = 1'b1;
    localparam logic VALID        = 1'b1;
    localparam int   BYTE_W       = 8;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        FILL   = 3'd2,
        RESP   = 3'd3,
        WRITE  = 3'd4
    } state_t;
endpackage

// File: rtl/icache_refill_ctrl_refill_byte_assembler.sv
// refill_byte_assembler: issue/receive counters and little-endian word assembly for one cache line refill.
module refill_byte_assembler
    import icache_refill_ctrl_pkg::*;
#(
    parameter int INST_W = INST_LEN,
    parameter int BYTES  = INST_W / BYTE_W,
    parameter int CW     = $clog2(BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              grant,
    input  logic              abort,
    input  logic [BYTE_W-1:0] rdata,
    output logic [CW-1:0]     issue_idx,
    output logic              issuing,
    output logic              done,
    output logic [INST_W-1:0] word
);
    logic [CW-1:0] recv_cnt;
    logic          in_flight;
    assign issuing = issue_idx < CW'(BYTES);
    // done fires while the last byte is being captured so WRITE follows immediately
    assign done = in_flight && recv_cnt == CW'(BYTES - 1);
    always_ff @(posedge clk)
        if (rst == RESET_ENABLE || abort || start) begin
            issue_idx <= '0;
            recv_cnt  <= '0;
            in_flight <= 1'b0;
            word      <= '0;
        end else begin
            if (grant && issuing) issue_idx <= issue_idx + CW'(1);
            in_flight <= grant && issuing;
            if (in_flight) begin
                word[BYTE_W*recv_cnt +: BYTE_W] <= rdata;
                recv_cnt <= recv_cnt + CW'(1);
            end
        end
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: IF-side I-cache lookup with byte-wise memory refill on a miss.
// Define IFETCH_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counters.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int INST_W = INST_LEN,
    parameter int BYTES  = INST_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              flush,
    output logic              fetch_ack,
    output logic [INST_W-1:0] fetch_inst,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
`endif
    output logic [ADDR_W-1:0] cache_addr,
    input  logic [INST_W-1:0] cache_data,
    input  logic              cache_hit,
    output logic [INST_W-1:0] cache_wdata,
    output logic              cache_replace,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_grant,
    input  logic [BYTE_W-1:0] mem_rdata
);
    localparam int CW = $clog2(BYTES + 1);
    state_t            state, next;
    logic [ADDR_W-1:0] base;
    logic [INST_W-1:0] inst_q, word;
    logic [CW-1:0]     issue_idx;
    logic              issuing, done;
    refill_byte_assembler #(.INST_W(INST_W), .BYTES(BYTES)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .start     (state == LOOKUP && cache_hit != VALID),
        .grant     (mem_req && mem_grant),
        .abort     (flush),
        .rdata     (mem_rdata),
        .issue_idx (issue_idx),
        .issuing   (issuing),
        .done      (done),
        .word      (word)
    );
    always_ff @(posedge clk)
        if (rst == RESET_ENABLE) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (fetch_req) next = LOOKUP;
            LOOKUP:  next = cache_hit == VALID ? RESP : FILL;
            FILL:    if (done) next = WRITE;
            default: next = IDLE;
        endcase
        if (flush) next = IDLE;
        // a flushed WRITE still refills the cache with correct data, only the ack is dropped
        fetch_ack     = (state == RESP || state == WRITE) && !flush;
        fetch_inst    = state == WRITE ? word : inst_q;
        cache_addr    = (state == LOOKUP || state == WRITE) ? base : '0;
        cache_replace = state == WRITE;
        cache_wdata   = cache_replace ? word : '0;
        mem_req       = state == FILL && issuing;
        mem_addr      = mem_req ? base + ADDR_W'(issue_idx) : '0;
    end
    always_ff @(posedge clk)
        if (rst == RESET_ENABLE) begin
            base   <= '0;
            inst_q <= '0;
        end else begin
            if (state == IDLE && fetch_req && !flush) base <= fetch_addr & ~ADDR_W'(3);
            if (state == LOOKUP && cache_hit == VALID) inst_q <= cache_data;
        end
`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk)
        if (rst == RESET_ENABLE) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            hit_cnt  <= hit_cnt + 32'(cache_hit);
            miss_cnt <= miss_cnt + 32'(!cache_hit);
        end
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: table-driven per-cycle checks of icache_refill_ctrl against a cache and byte-memory model.
module tb_icache_refill_ctrl;
    logic        clk = 0, rst = 1, fetch_req = 0, flush = 0, mem_grant = 0, inv = 1;
    logic [31:0] fetch_addr = 0;
    logic        fetch_ack, cache_hit, cache_replace, mem_req;
    logic [31:0] fetch_inst, cache_addr, cache_data, cache_wdata, mem_addr;
    logic [7:0]  mem_rdata;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif
    always #5 clk = ~clk;
    icache_refill_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .flush         (flush),
        .fetch_ack     (fetch_ack),
        .fetch_inst    (fetch_inst),
`ifdef IFETCH_PERF_CNT_EN
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt),
`endif
        .cache_addr    (cache_addr),
        .cache_data    (cache_data),
        .cache_hit     (cache_hit),
        .cache_wdata   (cache_wdata),
        .cache_replace (cache_replace),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_grant     (mem_grant),
        .mem_rdata     (mem_rdata)
    );
    // 16-entry direct-mapped cache; inv empties it and preloads 0x1000 = 0x00000013
    logic [15:0] cv;
    logic [31:0] ctag [16];
    logic [31:0] cdat [16];
    wire  [3:0]  ci = cache_addr[5:2];
    assign cache_hit  = cv[ci] && ctag[ci] == (cache_addr & ~32'h3F);
    assign cache_data = cdat[ci];
    always @(posedge clk)
        if (inv) begin
            cv      <= 16'h0001;
            ctag[0] <= 32'h1000;
            cdat[0] <= 32'h13;
        end else if (cache_replace) begin
            cv[ci]   <= 1'b1;
            ctag[ci] <= cache_addr & ~32'h3F;
            cdat[ci] <= cache_wdata;
        end
    function automatic logic [7:0] mbyte(logic [31:0] a);
        case (a)
            32'h2000: return 8'h13;
            32'h2001: return 8'h05;
            32'h2002, 32'h2003: return 8'h00;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction
    // ungranted cycles return junk so a capture during a stall corrupts the word
    always @(posedge clk) mem_rdata <= (mem_req && mem_grant) ? mbyte(mem_addr) : 8'hEE;

    typedef struct {
        logic rst, req, fl, gnt, iv, z;
        logic [31:0] addr;
        logic ack; logic [31:0] inst;
        logic mreq; logic [31:0] maddr;
        logic repl; logic [31:0] wdata;
        logic cc; logic [31:0] ca;
    } vec_t;
    vec_t vq[$];
    int total = 0, passed = 0;

    function automatic void add(logic rs, logic rq, logic [31:0] a, logic fl, logic g, logic iv, logic z,
                                logic ak, logic [31:0] in, logic mr, logic [31:0] ma,
                                logic rp, logic [31:0] wd, logic cc, logic [31:0] ca);
        vec_t v;
        v.rst = rs; v.req = rq; v.addr = a; v.fl = fl; v.gnt = g; v.iv = iv; v.z = z;
        v.ack = ak; v.inst = in; v.mreq = mr; v.maddr = ma; v.repl = rp; v.wdata = wd; v.cc = cc; v.ca = ca;
        vq.push_back(v);
    endfunction
    function automatic void zero();
        add(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic void idle(logic rq, logic [31:0] a, logic fl, logic iv);
        add(0, rq, a, fl, 1, iv, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic void look(logic [31:0] a);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, a);
    endfunction
    function automatic void resp(logic [31:0] w);
        add(0, 0, 0, 0, 1, 0, 0, 1, w, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic void fill(logic mr, logic [31:0] ma, logic g, logic fl, logic rs);
        add(rs, 0, 0, fl, g, 0, 0, 0, 0, mr, ma, 0, 0, 0, 0);
    endfunction
    function automatic void wr(logic [31:0] a, logic [31:0] w, logic fl);
        add(0, 0, 0, fl, 1, 0, 0, !fl, w, 0, 0, 1, w, 1, a);
    endfunction
    // miss of 0x2000 with continuous grant: issue C2-C5, WRITE C7
    function automatic void miss(logic iv, logic flw);
        idle(1, 32'h2000, 0, iv);
        look(32'h2000);
        fill(1, 32'h2000, 1, 0, 0);
        fill(1, 32'h2001, 1, 0, 0);
        fill(1, 32'h2002, 1, 0, 0);
        fill(1, 32'h2003, 1, 0, 0);
        fill(0, 0, 1, 0, 0);
        wr(32'h2000, 32'h0000_0513, flw);
        idle(0, 0, 0, 0);
    endfunction

    task automatic chk(string n, int i, logic [31:0] a, logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s row %0d: got %h expected %h", n, i, a, e);
    endtask

    initial begin
        zero();
        // hit on 0x1002 -> word at 0x1000, ack in C2
        idle(1, 32'h1002, 0, 0); look(32'h1000); resp(32'h13); idle(0, 0, 0, 0);
        // request coincident with flush is dropped
        idle(1, 32'h1000, 1, 0); idle(0, 0, 0, 0); idle(0, 0, 0, 0);
        miss(1, 0);
        // grant low for two cycles after byte 1: address holds at 0x2002, ack in C9
        idle(1, 32'h2000, 0, 1); look(32'h2000);
        fill(1, 32'h2000, 1, 0, 0); fill(1, 32'h2001, 1, 0, 0);
        fill(1, 32'h2002, 0, 0, 0); fill(1, 32'h2002, 0, 0, 0);
        fill(1, 32'h2002, 1, 0, 0); fill(1, 32'h2003, 1, 0, 0);
        fill(0, 0, 1, 0, 0); wr(32'h2000, 32'h0000_0513, 0); idle(0, 0, 0, 0);
        // flush in WRITE: replace happens, ack suppressed; the line then hits
        miss(1, 1);
        idle(1, 32'h2000, 0, 0); look(32'h2000); resp(32'h0000_0513); idle(0, 0, 0, 0);
        // flush the cycle after byte 2 issues, then a clean refill
        idle(1, 32'h2000, 0, 1); look(32'h2000);
        fill(1, 32'h2000, 1, 0, 0); fill(1, 32'h2001, 1, 0, 0); fill(1, 32'h2002, 1, 0, 0);
        fill(1, 32'h2003, 1, 1, 0); idle(0, 0, 0, 0); idle(0, 0, 0, 0);
        miss(0, 0);
        // reset mid-FILL, then a clean refill
        idle(1, 32'h2000, 0, 1); look(32'h2000);
        fill(1, 32'h2000, 1, 0, 0); fill(1, 32'h2001, 1, 0, 1); zero();
        miss(0, 0);
        for (int k = 0; k < 3; k++) begin
            idle(1, 32'h2000, 0, 0); look(32'h2000); resp(32'h0000_0513);
        end
        idle(1, 32'h3000, 0, 0); look(32'h3000); fill(1, 32'h3000, 1, 1, 0);
        idle(0, 0, 0, 0); idle(0, 0, 0, 0);

        repeat (3) @(posedge clk);
        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; fetch_req = vq[i].req; fetch_addr = vq[i].addr;
            flush = vq[i].fl; mem_grant = vq[i].gnt; inv = vq[i].iv;
            #1;
            chk("fetch_ack", i, 32'(fetch_ack), 32'(vq[i].ack));
            chk("mem_req", i, 32'(mem_req), 32'(vq[i].mreq));
            chk("cache_replace", i, 32'(cache_replace), 32'(vq[i].repl));
            if (vq[i].ack || vq[i].z) chk("fetch_inst", i, fetch_inst, vq[i].inst);
            if (vq[i].mreq || vq[i].z) chk("mem_addr", i, mem_addr, vq[i].maddr);
            if (vq[i].repl || vq[i].z) chk("cache_wdata", i, cache_wdata, vq[i].wdata);
            if (vq[i].cc || vq[i].z) chk("cache_addr", i, cache_addr, vq[i].ca);
        end
`ifdef IFETCH_PERF_CNT_EN
        chk("hit_cnt", -1, hit_cnt, 32'd3);
        chk("miss_cnt", -1, miss_cnt, 32'd2);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
